sum4: RTL and testbench
=======================

Name: sum4

Overview:
- 4-bit binary adder with carry-in and carry-out: a purely combinational sum path plus a registered copy of the result for synchronous consumers.
- Datapath leaf block used wherever a small word add (A + B + c_in) is needed.
- Combinational outputs give same-delta results; registered outputs give a 1-cycle-latency, reset-clean version.

Parameters:
- WIDTH, 4, operand/sum width in bits. All behaviour is specified for the default; any WIDTH >= 1 shall also work.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset; clears all registered outputs.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry-in, weight 1.
- S  output  WIDTH  combinational sum bits, (A+B+c_in) mod 2^WIDTH.
- c_out  output  1  combinational carry-out, bit WIDTH of A+B+c_in.
- ovf  output  1  combinational two's-complement overflow: carry into MSB XOR carry out of MSB.
- S_q  output  WIDTH  registered S.
- c_out_q  output  1  registered c_out.
- ovf_q  output  1  registered ovf.
- par_q  output  1  registered even parity of S (XOR of all S bits); see Optional Feature.

Behaviour:
- Core structure: ripple-carry chain of WIDTH full-adder cells.
  - Cell i: s_i = A_i ^ B_i ^ c_i; c_(i+1) = A_i&B_i | c_i&(A_i^B_i).
  - c_0 = c_in; c_out = c_WIDTH; ovf = c_(WIDTH-1) ^ c_WIDTH.
- Combinational outputs:
  - {c_out,S} = A + B + c_in exactly, computed at WIDTH+1 bits; no truncation before the carry.
  - No clock dependency; must settle well within 20 ns of any input change.
- Registered outputs:
  - On every rising clk with rst_n=1: S_q<=S, c_out_q<=c_out, ovf_q<=ovf, par_q<=^S (or 0, see below).
  - Latency exactly 1 cycle; no enable, updates every cycle.
- Reset:
  - rst_n=0 immediately (asynchronously) forces S_q=0, c_out_q=0, ovf_q=0, par_q=0.
  - Registered outputs hold 0 while rst_n=0.
  - First capture occurs on the first rising clk after rst_n deasserts.
  - Combinational outputs S, c_out, ovf are unaffected by reset and always track the inputs.
  - Reset asserted mid-stream discards the in-flight registered value; no recovery of it.
- Boundaries:
  - Max: A=B=all-ones, c_in=1 -> S=all-ones, c_out=1.
  - Wrap-around: A=all-ones, B=0, c_in=1 -> S=0, c_out=1.
  - c_in alone propagates through the full chain: A=all-ones, B=0.
- X/Z on inputs need not be resolved; no internal state other than the output registers.

Optional Feature:
- Macro SUM4_PARITY_EN.
- Defined: par_q registers the XOR-reduction of S each cycle; reset value 0.
- Not defined: par_q is a constant 0 and no parity logic or flop is synthesized.
- The port list is identical in both builds; all other outputs are unaffected.

Test Plan:
- A=0000, B=0000, c_in=0 -> S=0000, c_out=0, ovf=0; next clk S_q=0000.
- Sweep A=0000, B=0000..0110, c_in=0/1, 20 ns per vector:
  - B=0011, c_in=1 -> S=0100, c_out=0.
  - B=0110, c_in=1 -> S=0111, c_out=0.
  - Registered outputs lag by one clk.
- A=1111, B=1111, c_in=1 -> S=1111, c_out=1, ovf=0.
- A=0111, B=0001, c_in=0 -> S=1000, c_out=0, ovf=1.
- A=1111, B=0000, c_in=1 -> S=0000, c_out=1.
  - With SUM4_PARITY_EN: par_q=0 after clk.
  - A=0000, B=0001, c_in=0 -> par_q=1.
- Load A=0101, B=0011, c_in=0 and clock (S_q=1000), then pull rst_n low between edges:
  - S_q, c_out_q, ovf_q, par_q drop to 0 without a clk edge.
  - S stays 1000.
  - After release, first clk restores S_q=1000.

Source files
------------

// File: rtl/sum4.sv
// Ripple-carry WIDTH-bit adder with combinational sum/carry/overflow and a registered copy.
// Optional macro SUM4_PARITY_EN adds a registered even-parity bit of S on par_q.
module sum4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic [WIDTH-1:0] S,
  output logic             c_out,
  output logic             ovf,
  output logic [WIDTH-1:0] S_q,
  output logic             c_out_q,
  output logic             ovf_q,
  output logic             par_q
);

  logic [WIDTH:0] carry;

  // NOTE: blocking assignments here so each cell sees the carry computed just above it.
  always_comb begin
    carry    = '0;
    S        = '0;
    carry[0] = c_in;
    for (int i = 0; i < WIDTH; i++) begin
      S[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
  end

  assign c_out = carry[WIDTH];
  assign ovf   = carry[WIDTH-1] ^ carry[WIDTH];

  // NOTE: non-blocking assignments for all flops; reset is asynchronous and clears every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      S_q     <= S;
      c_out_q <= c_out;
      ovf_q   <= ovf;
    end
  end

`ifdef SUM4_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= ^S;
  end
`else
  assign par_q = 1'b0;
`endif

endmodule

// File: tb/tb_sum4.sv
// Scoreboard bench for sum4: directed boundary vectors, a random sweep and a mid-stream reset.
module tb_sum4;

  localparam int W = 4;

  typedef struct {
    int s;
    int c;
    int o;
    int p;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] A, B;
  logic         c_in;
  logic [W-1:0] S, S_q;
  logic         c_out, ovf, c_out_q, ovf_q, par_q;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  sum4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .c_in(c_in),
    .S(S), .c_out(c_out), .ovf(ovf),
    .S_q(S_q), .c_out_q(c_out_q), .ovf_q(ovf_q), .par_q(par_q)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic, with overflow judged on signed operand values.
  function automatic exp_t model(input int a, input int b, input int ci);
    exp_t e;
    int   mod  = 1 << W;
    int   half = 1 << (W - 1);
    int   sum  = a + b + ci;
    int   sa   = (a >= half) ? a - mod : a;
    int   sbv  = (b >= half) ? b - mod : b;
    int   ssum = sa + sbv + ci;
    e.s = sum % mod;
    e.c = sum / mod;
    e.o = (ssum >= half || ssum < -half) ? 1 : 0;
`ifdef SUM4_PARITY_EN
    e.p = $countones(e.s) % 2;
`else
    e.p = 0;
`endif
    return e;
  endfunction

  // Drive on the falling edge, check combinational outputs, queue the registered expectation.
  task automatic apply(input int a, input int b, input int ci);
    exp_t e;
    @(negedge clk);
    A = W'(a); B = W'(b); c_in = ci[0];
    #1;
    e = model(a, b, ci);
    check("S", int'(S), e.s);
    check("c_out", int'(c_out), e.c);
    check("ovf", int'(ovf), e.o);
    sb_q.push_back(e);
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, "_S_q"}, int'(S_q), 0);
    check({tag, "_c_out_q"}, int'(c_out_q), 0);
    check({tag, "_ovf_q"}, int'(ovf_q), 0);
    check({tag, "_par_q"}, int'(par_q), 0);
  endtask

  // Monitor: registered outputs are presented one clock after each queued vector.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("S_q", int'(S_q), e.s);
        check("c_out_q", int'(c_out_q), e.c);
        check("ovf_q", int'(ovf_q), e.o);
        check("par_q", int'(par_q), e.p);
      end
    end
  end

  initial begin
    rst_n = 1'b0; A = '0; B = '0; c_in = 1'b0;
    #5;
    check_regs_zero("rst");
    check("rst_S", int'(S), 0);
    check("rst_c_out", int'(c_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    apply(0, 0, 0);
    for (int b = 0; b <= 6; b++)
      for (int ci = 0; ci <= 1; ci++)
        apply(0, b, ci);
    apply(15, 15, 1);
    apply(7, 1, 0);
    apply(15, 0, 1);
    apply(0, 1, 0);
    apply(8, 8, 0);
    apply(8, 15, 0);
    for (int n = 0; n < 200; n++)
      apply(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));

    // Mid-stream reset: registers clear with no clock edge, combinational path unaffected.
    apply(5, 3, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_regs_zero("async");
    check("async_S", int'(S), 8);
    @(posedge clk);
    #1;
    check_regs_zero("hold");
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(model(5, 3, 0));
    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
